rib_arbiter: RTL and testbench

RIB_ARBITER -- requirements
Module: rib_arbiter

---
 rtl/rib_arbiter_pkg.sv | 29 ++
 rtl/rr_pick3.sv | 26 ++
 rtl/rib_arbiter.sv | 114 +++++++++++
 tb/tb_rib_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rib_arbiter_pkg.sv
// Shared types and constants for the RIB bus arbiter.
package rib_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } rib_state_t;

  localparam logic [7:0]  RIB_TIMEOUT = 8'd255;
  localparam int unsigned INST_ADDR_W = 32;
  localparam logic        HOLD_ENABLE = 1'b1;

  // Master indices
  localparam int unsigned M_EX   = 0;
  localparam int unsigned M_PC   = 1;
  localparam int unsigned M_UART = 2;
  localparam int unsigned M_JTAG = 3;

  // Index of the set bit in a one-hot grant; 0 when nothing is set.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin picker: first requester at or after rr_ptr wins.
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] rr_ptr,
  output logic [2:0] win
);

  logic [2:0] rot;
  logic [2:0] pick;

  // Rotate so rr_ptr sits at bit 0, pick lowest, rotate the winner back.
  always_comb begin
    case (rr_ptr)
      2'd1:    rot = {req[0], req[2], req[1]};
      2'd2:    rot = {req[1], req[0], req[2]};
      default: rot = req;
    endcase
    pick = rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
    case (rr_ptr)
      2'd1:    win = {pick[1], pick[0], pick[2]};
      2'd2:    win = {pick[0], pick[2], pick[1]};
      default: win = pick;
    endcase
  end

endmodule

// File: rtl/rib_arbiter.sv
// RIB bus arbiter: four masters onto one slave, jtag fixed priority,
// round-robin among the other three, per-transaction timeout.
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = RIB_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             m_req_i,
  input  logic [127:0]           m_addr_i,
  input  logic [3:0]             m_we_i,
  input  logic [127:0]           m_wdata_i,
  output logic [3:0]             m_grant_o,
  output logic [3:0]             m_ack_o,
  output logic [3:0]             m_err_o,
  output logic [31:0]            m_rdata_o,
  output logic                   s_req_o,
  output logic                   s_we_o,
  output logic [INST_ADDR_W-1:0] s_addr_o,
  output logic [31:0]            s_wdata_o,
  input  logic                   s_ack_i,
  input  logic [31:0]            s_rdata_i,
  output logic                   hold_flag_o
);

  rib_state_t state;
  logic [1:0] rr_ptr;
  logic [7:0] tmo_cnt;
  logic [1:0] g_idx;
  logic [2:0] rr_win;
  logic [3:0] win;
  logic       busy;
  logic       live;
  logic       ack;
  logic       err;

  rr_pick3 u_pick (
    .req    (m_req_i[2:0]),
    .rr_ptr (rr_ptr),
    .win    (rr_win)
  );

  // Winner selection and transaction status for the granted master.
  always_comb begin
    win   = m_req_i[M_JTAG] ? 4'b1000 : {1'b0, rr_win};
    g_idx = onehot_to_idx(m_grant_o);
    busy  = (state == ST_BUSY);
    live  = busy & m_req_i[g_idx];
    ack   = live & s_ack_i;
    err   = live & ~s_ack_i & (tmo_cnt == TIMEOUT - 8'd1);
  end

  // Slave-side mux and master-side completion outputs.
  always_comb begin
    s_req_o   = '0;
    s_we_o    = '0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    m_rdata_o = '0;
    if (busy) begin
      s_req_o   = m_req_i[g_idx];
      s_we_o    = m_we_i[g_idx];
      s_addr_o  = m_addr_i[{g_idx, 5'b0} +: 32];
      s_wdata_o = m_wdata_i[{g_idx, 5'b0} +: 32];
    end
    if (ack) begin
      m_ack_o   = m_grant_o;
      m_rdata_o = s_rdata_i;
    end
    if (err) m_err_o = m_grant_o;
  end

  // Fetch stall; forced low while reset is asserted.
  always_comb begin
    hold_flag_o = rst & HOLD_ENABLE & m_req_i[M_PC] & ~m_ack_o[M_PC];
  end

  // Arbitration FSM with registered grant, rr pointer and timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      m_grant_o <= '0;
      rr_ptr    <= '0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|m_req_i) begin
            state     <= ST_BUSY;
            m_grant_o <= win;
            tmo_cnt   <= '0;
          end
        end
        ST_BUSY: begin
          if (ack | err | ~live) begin
            state     <= ST_IDLE;
            m_grant_o <= '0;
            // Abandoned (request dropped) and jtag transactions keep the pointer.
            if ((ack | err) && (g_idx != 2'(M_JTAG))) begin
              rr_ptr <= (g_idx == 2'(M_UART)) ? 2'(M_EX) : g_idx + 2'd1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rib_arbiter.sv
// Self-checking bench for rib_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_rib_arbiter;

  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   m_req = '0;
  logic [127:0] m_addr = '0;
  logic [3:0]   m_we = '0;
  logic [127:0] m_wdata = '0;
  logic [3:0]   m_grant, m_ack, m_err;
  logic [31:0]  m_rdata;
  logic         s_req, s_we;
  logic [31:0]  s_addr, s_wdata;
  logic         s_ack = 1'b0;
  logic [31:0]  s_rdata = '0;
  logic         hold_flag;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the bus, how many BUSY cycles so far, rr pointer.
  bit md_busy = 0;
  int md_owner = 0;
  int md_cycles = 0;
  int md_ptr = 0;

  // Last sampled DUT outputs, for directed expectations.
  logic [3:0]  lg, la, le;
  logic [31:0] lrd, lsaddr;
  logic        lhold;

  rib_arbiter #(.TIMEOUT(8'(TO))) dut (
    .clk         (clk),
    .rst         (rst),
    .m_req_i     (m_req),
    .m_addr_i    (m_addr),
    .m_we_i      (m_we),
    .m_wdata_i   (m_wdata),
    .m_grant_o   (m_grant),
    .m_ack_o     (m_ack),
    .m_err_o     (m_err),
    .m_rdata_o   (m_rdata),
    .s_req_o     (s_req),
    .s_we_o      (s_we),
    .s_addr_o    (s_addr),
    .s_wdata_o   (s_wdata),
    .s_ack_i     (s_ack),
    .s_rdata_i   (s_rdata),
    .hold_flag_o (hold_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at posedge+1 with inputs driven; checks outputs, advances model, returns at next posedge+1.
  task automatic tick();
    logic [3:0]  eg, ea, ee;
    logic [31:0] erd, eaddr, ewd;
    logic        esreq, ewe, ehold;
    bit act;
    #2;
    eg    = md_busy ? 4'(1 << md_owner) : 4'b0;
    act   = md_busy && m_req[md_owner];
    ea    = (act && s_ack) ? eg : 4'b0;
    ee    = (act && !s_ack && md_cycles == TO) ? eg : 4'b0;
    erd   = (ea != 0) ? s_rdata : 32'h0;
    esreq = md_busy ? m_req[md_owner] : 1'b0;
    ewe   = md_busy ? m_we[md_owner] : 1'b0;
    eaddr = md_busy ? m_addr[32*md_owner +: 32] : 32'h0;
    ewd   = md_busy ? m_wdata[32*md_owner +: 32] : 32'h0;
    ehold = m_req[1] && !ea[1];
    lg = m_grant; la = m_ack; le = m_err; lrd = m_rdata; lsaddr = s_addr; lhold = hold_flag;
    chk("grant", 32'(m_grant), 32'(eg));
    chk("ack", 32'(m_ack), 32'(ea));
    chk("err", 32'(m_err), 32'(ee));
    chk("rdata", m_rdata, erd);
    chk("s_req", 32'(s_req), 32'(esreq));
    chk("s_we", 32'(s_we), 32'(ewe));
    chk("s_addr", s_addr, eaddr);
    chk("s_wdata", s_wdata, ewd);
    chk("hold", 32'(hold_flag), 32'(ehold));
    if (md_busy) begin
      if (ea != 0 || ee != 0) begin
        md_busy = 0;
        if (md_owner < 3) md_ptr = (md_owner + 1) % 3;
      end else if (!act) begin
        md_busy = 0;
      end else begin
        md_cycles++;
      end
    end else if (m_req != 0) begin
      md_busy = 1;
      md_cycles = 1;
      if (m_req[3]) md_owner = 3;
      else begin
        for (int k = 0; k < 3; k++) begin
          if (m_req[(md_ptr + k) % 3]) begin
            md_owner = (md_ptr + k) % 3;
            break;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; asserts reset mid-cycle, checks outputs, releases at posedge+3.
  task automatic do_reset();
    rst = 1'b0;
    #2;
    chk("rst_grant", 32'(m_grant), 32'h0);
    chk("rst_ack", 32'(m_ack), 32'h0);
    chk("rst_err", 32'(m_err), 32'h0);
    chk("rst_rdata", m_rdata, 32'h0);
    chk("rst_sreq", 32'(s_req), 32'h0);
    chk("rst_saddr", s_addr, 32'h0);
    chk("rst_swdata", s_wdata, 32'h0);
    chk("rst_hold", 32'(hold_flag), 32'h0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    md_busy = 0; md_cycles = 0; md_ptr = 0; md_owner = 0;
  endtask

  initial begin
    logic [3:0] exp37 [0:7];
    exp37 = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h1};

    @(posedge clk); #1;
    do_reset();

    // m1 alone, ack on third BUSY cycle
    m_req = 4'b0010; m_addr[63:32] = 32'h0000_0100; s_ack = 0;
    tick(); chk("r36_idle_hold", 32'(lhold), 32'h1);
    tick(); chk("r36_grant", 32'(lg), 32'h2); chk("r36_addr", lsaddr, 32'h100);
    tick(); chk("r36_hold_b2", 32'(lhold), 32'h1);
    s_ack = 1; s_rdata = 32'hDEAD_BEEF;
    tick(); chk("r36_ack", 32'(la), 32'h2); chk("r36_rdata", lrd, 32'hDEAD_BEEF);
    chk("r36_hold_ack", 32'(lhold), 32'h0);
    m_req = '0; s_ack = 0;
    tick();

    // m0..m2 held, immediate acks
    do_reset();
    m_req = 4'b0111; s_ack = 1; s_rdata = 32'h1234_5678;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("r37_grant", 32'(lg), 32'(exp37[i]));
    end
    m_req = '0; s_ack = 0;
    tick();

    // m3 beats m0, pointer unaffected
    do_reset();
    m_req = 4'b1001; s_ack = 1;
    tick();
    tick(); chk("r38_m3", 32'(lg), 32'h8); chk("r38_ack", 32'(la), 32'h8);
    m_req = 4'b0001;
    tick();
    tick(); chk("r38_m0", 32'(lg), 32'h1);
    m_req = '0; s_ack = 0;
    tick();

    // timeout on m2, then ack coinciding with the timeout cycle
    do_reset();
    m_req = 4'b0100; s_ack = 0;
    tick();
    for (int i = 1; i <= 3; i++) begin
      tick(); chk("r39_noerr", 32'(le), 32'h0);
    end
    tick(); chk("r39_err", 32'(le), 32'h4);
    tick(); chk("r39_idle", 32'(lg), 32'h0);
    tick(); tick(); tick();
    s_ack = 1;
    tick(); chk("r39_ack", 32'(la), 32'h4); chk("r39_ack_noerr", 32'(le), 32'h0);
    m_req = '0; s_ack = 0;
    tick();

    // reset in the middle of a BUSY transaction
    do_reset();
    m_req = 4'b0001; m_addr[31:0] = 32'h40; s_ack = 0;
    tick(); tick();
    m_req = 4'b0011;
    do_reset();
    s_ack = 1;
    tick(); chk("r40_noack", 32'(la), 32'h0); chk("r40_noerr", 32'(le), 32'h0);
    tick(); chk("r40_ptr0", 32'(lg), 32'h1);
    m_req = '0; s_ack = 0;
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(7) == 0) m_req[b] = ~m_req[b];
      if (m_req[3]) begin
        if ($urandom_range(2) == 0) m_req[3] = 1'b0;
      end else if ($urandom_range(31) == 0) m_req[3] = 1'b1;
      m_addr  = {$urandom, $urandom, $urandom, $urandom};
      m_wdata = {$urandom, $urandom, $urandom, $urandom};
      m_we    = 4'($urandom);
      s_ack   = ($urandom_range(2) == 0);
      s_rdata = $urandom;
      if ($urandom_range(199) == 0) do_reset();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
